// File: rtl/bit_count_pkg.sv
// Shared types for the multi-mode bit counter: operation select and FSM states.
package bit_count_pkg;

  typedef enum logic [1:0] {
    ONES  = 2'd0,
    ZEROS = 2'd1,
    LZC   = 2'd2,
    TZC   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/bidir_shift_reg.sv
// Operand register: parallel load, or one-bit shift left/right with zero fill.
module bidir_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             CLOCK_50,
  input  logic             Reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             shift_en,
  input  logic             dir_left,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (load)
      q_d = load_val;
    else if (shift_en)
      q_d = dir_left ? {q_q[WIDTH-2:0], 1'b0} : {1'b0, q_q[WIDTH-1:1]};
  end

  always_ff @(posedge CLOCK_50) begin
    if (Reset) q_q <= '0;
    else       q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/multi_mode_bit_counter.sv
// Serial bit counter: ones, zeros, leading zeros or trailing zeros, one bit per cycle.
module multi_mode_bit_counter
  import bit_count_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int RW = $clog2(WIDTH + 1)
) (
  input  logic             CLOCK_50,
  input  logic             Reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  input  logic [1:0]       mode,
  output logic             busy,
  output logic             done,
  output logic [RW-1:0]    result
);

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [RW-1:0]    cnt_q, cnt_d;
  logic [RW-1:0]    idx_q, idx_d;
  logic [RW-1:0]    res_q, res_d;
  logic [WIDTH-1:0] opnd;
  logic             load, shift_en, dir_left, bit_sel;

  assign load     = (state_q == IDLE);
  assign dir_left = (mode_q == LZC);
  assign bit_sel  = dir_left ? opnd[WIDTH-1] : opnd[0];

  bidir_shift_reg #(.WIDTH(WIDTH)) u_opnd (
    .CLOCK_50 (CLOCK_50),
    .Reset    (Reset),
    .load     (load),
    .load_val (data_in),
    .shift_en (shift_en),
    .dir_left (dir_left),
    .q        (opnd)
  );

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    res_d    = res_q;
    shift_en = 1'b0;
    unique case (state_q)
      IDLE: begin
        mode_d = mode_e'(mode);
        if (start) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = COUNT;
        end
      end
      COUNT: begin
        // Population modes stop once the remaining operand is empty; zero-count
        // modes stop at the first 1 or after the whole word has been scanned.
        if ((mode_q == ONES) || (mode_q == ZEROS)) begin
          if (opnd == '0) begin
            state_d = DONE;
            res_d   = (mode_q == ZEROS) ? RW'(WIDTH) - cnt_q : cnt_q;
          end else begin
            cnt_d    = cnt_q + RW'(opnd[0]);
            idx_d    = idx_q + 1'b1;
            shift_en = 1'b1;
          end
        end else begin
          if (bit_sel || (idx_q == RW'(WIDTH))) begin
            state_d = DONE;
            res_d   = cnt_q;
          end else begin
            cnt_d    = cnt_q + 1'b1;
            idx_d    = idx_q + 1'b1;
            shift_en = 1'b1;
          end
        end
      end
      DONE: begin
        if (!start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      state_q <= IDLE;
      mode_q  <= ONES;
      cnt_q   <= '0;
      idx_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      res_q   <= res_d;
    end
  end

  assign busy   = (state_q == COUNT);
  assign done   = (state_q == DONE);
  assign result = res_q;

endmodule

// File: tb/tb_multi_mode_bit_counter.sv
// Directed bench: 8-bit and 16-bit counters, hand-computed results and latencies.
module tb_multi_mode_bit_counter;

  logic        CLOCK_50 = 1'b0;
  logic        Reset;
  logic        start8, start16;
  logic [15:0] data;
  logic [1:0]  mode;
  logic        busy8, done8, busy16, done16;
  logic [3:0]  result8;
  logic [4:0]  result16;
  int          n_chk = 0;
  int          n_err = 0;

  always #10 CLOCK_50 = ~CLOCK_50;

  multi_mode_bit_counter #(.WIDTH(8)) dut8 (
    .CLOCK_50 (CLOCK_50),
    .Reset    (Reset),
    .start    (start8),
    .data_in  (data[7:0]),
    .mode     (mode),
    .busy     (busy8),
    .done     (done8),
    .result   (result8)
  );

  multi_mode_bit_counter #(.WIDTH(16)) dut16 (
    .CLOCK_50 (CLOCK_50),
    .Reset    (Reset),
    .start    (start16),
    .data_in  (data),
    .mode     (mode),
    .busy     (busy16),
    .done     (done16),
    .result   (result16)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic cur_busy(input bit w16);
    return w16 ? busy16 : busy8;
  endfunction
  function automatic logic cur_done(input bit w16);
    return w16 ? done16 : done8;
  endfunction
  function automatic logic [31:0] cur_res(input bit w16);
    return w16 ? 32'(result16) : 32'(result8);
  endfunction

  // Entered at a negedge; starts a job, measures COUNT cycles, returns to IDLE.
  task automatic run(input string tag, input bit w16, input logic [1:0] m,
                     input logic [15:0] d, input int exp_r, input int exp_c);
    int cyc;
    mode = m;
    data = d;
    if (w16) start16 = 1'b1; else start8 = 1'b1;
    @(posedge CLOCK_50); #1;
    cyc = 0;
    while (cur_busy(w16) && cyc < 100) begin
      if (cur_done(w16)) chk({tag, "_done_in_count"}, 1, 0);
      cyc++;
      @(posedge CLOCK_50); #1;
    end
    chk({tag, "_cycles"}, cyc, exp_c);
    chk({tag, "_done"}, 32'(cur_done(w16)), 1);
    chk({tag, "_result"}, cur_res(w16), exp_r);
    start8 = 1'b0; start16 = 1'b0;
    @(posedge CLOCK_50); #1;
    chk({tag, "_idle"}, 32'({cur_busy(w16), cur_done(w16)}), 0);
    chk({tag, "_hold"}, cur_res(w16), exp_r);
    @(negedge CLOCK_50);
  endtask

  initial begin
    Reset = 1'b1; start8 = 1'b0; start16 = 1'b0; data = '0; mode = 2'd0;
    repeat (3) @(posedge CLOCK_50);
    #1;
    chk("rst_busy8", 32'(busy8), 0);
    chk("rst_done8", 32'(done8), 0);
    chk("rst_res8", 32'(result8), 0);
    chk("rst_res16", 32'(result16), 0);
    @(negedge CLOCK_50);
    Reset = 1'b0;
    // start in the very first cycle after reset release
    run("ones_b5",  0, 2'd0, 16'h00B5, 5, 9);
    run("zeros_b5", 0, 2'd1, 16'h00B5, 3, 9);
    run("ones_00",  0, 2'd0, 16'h0000, 0, 1);
    run("lzc_10",   0, 2'd2, 16'h0010, 3, 4);
    run("tzc_10",   0, 2'd3, 16'h0010, 4, 5);
    run("lzc_00",   0, 2'd2, 16'h0000, 8, 9);
    run("tzc_00",   0, 2'd3, 16'h0000, 8, 9);
    run("zeros_00", 0, 2'd1, 16'h0000, 8, 1);
    run("lzc_80",   0, 2'd2, 16'h0080, 0, 1);
    run("ones_16",  1, 2'd0, 16'hFFFF, 16, 17);
    run("tzc_16",   1, 2'd3, 16'h8000, 15, 16);

    // Reset in the 4th COUNT cycle of an 8-bit ONES job
    run("ones_0f",  0, 2'd0, 16'h000F, 4, 5);
    mode = 2'd0; data = 16'h00FF; start8 = 1'b1;
    @(posedge CLOCK_50); #1;
    chk("rst_mid_busy_before", 32'(busy8), 1);
    repeat (3) @(posedge CLOCK_50);
    #1;
    Reset = 1'b1; start8 = 1'b0;
    @(posedge CLOCK_50); #1;
    chk("rst_mid_busy", 32'(busy8), 0);
    chk("rst_mid_done", 32'(done8), 0);
    chk("rst_mid_res", 32'(result8), 0);
    @(negedge CLOCK_50);
    Reset = 1'b0;

    // start held through DONE while the operand changes
    mode = 2'd0; data = 16'h000F; start8 = 1'b1;
    @(posedge CLOCK_50); #1;
    repeat (5) @(posedge CLOCK_50);
    #1;
    chk("held_done_entry", 32'(done8), 1);
    data = 16'h00FF; mode = 2'd2;
    repeat (5) @(posedge CLOCK_50);
    #1;
    chk("held_done", 32'(done8), 1);
    chk("held_busy", 32'(busy8), 0);
    chk("held_res", 32'(result8), 4);
    start8 = 1'b0;
    @(posedge CLOCK_50); #1;
    chk("held_release_idle", 32'({busy8, done8}), 0);
    chk("held_release_res", 32'(result8), 4);
    @(negedge CLOCK_50);
    run("ones_ff",  0, 2'd0, 16'h00FF, 8, 9);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/multi_mode_bit_counter.md
MULTI_MODE_BIT_COUNTER -- requirements
Module: multi_mode_bit_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand width in bits; legal range 2..32.
REQ-002 SHALL have derived constant RW = clog2(WIDTH+1), meaning result width.
REQ-003 SHALL have port CLOCK_50  input  1  system clock; all state updates on rising edge.
REQ-004 SHALL have port Reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  level request; already synchronised by the instantiating top level.
REQ-006 SHALL have port data_in  input  WIDTH  operand, sampled only at load.
REQ-007 SHALL have port mode  input  2  operation select, sampled only at load: 0 ONES, 1 ZEROS, 2 LZC (leading zeros), 3 TZC (trailing zeros).
REQ-008 SHALL have port busy  output  1  high while in COUNT.
REQ-009 SHALL have port done  output  1  high while in DONE.
REQ-010 SHALL have port result  output  RW  registered count.

Function
REQ-011 SHALL implement a three-state FSM: IDLE, COUNT, DONE.
REQ-012 IDLE: operand register loads data_in and mode register loads mode every cycle; result holds its previous value; on start=1, SHALL clear the count register and move to COUNT next edge.
REQ-013 COUNT: SHALL examine exactly one bit per cycle; ONES/ZEROS/TZC examine LSB then shift right with zero fill; LZC examines MSB then shifts left with zero fill.
REQ-014 COUNT SHALL maintain a bit index 0..WIDTH incremented on each shift.
REQ-015 ONES/ZEROS: if the operand register is 0, go to DONE with no count or shift that cycle; else add LSB to count and shift.
REQ-016 LZC/TZC: if the examined bit is 1 or index = WIDTH, go to DONE with no count; else increment count and shift.
REQ-017 On the COUNT->DONE edge, result SHALL load count (ONES, LZC, TZC) or WIDTH - count (ZEROS).
REQ-018 ONES/ZEROS latency SHALL be (index of highest set bit + 2) cycles in COUNT, 1 cycle for a zero operand; LZC/TZC latency SHALL be answer + 1 cycles.
REQ-019 All-zero operand: LZC = TZC = WIDTH, ONES = 0, ZEROS = WIDTH.
REQ-020 DONE: SHALL hold result and done; go to IDLE only when start = 0; a start held high SHALL NOT retrigger.
REQ-021 start, data_in, and mode changes during COUNT or DONE SHALL have no effect.
REQ-022 result SHALL remain valid and unchanged from DONE until the next COUNT->DONE edge.
REQ-023 Count arithmetic SHALL be RW bits wide and SHALL NOT wrap for any legal WIDTH.

Reset
REQ-024 Reset SHALL take priority over all other inputs in any state, including mid-COUNT.
REQ-025 Reset SHALL force state IDLE, operand register, count, index, and result to 0, and busy = done = 0 on the following cycle.
REQ-026 If start = 1 in the first cycle after Reset is released, the FSM SHALL load and enter COUNT normally.

Structure
REQ-027 SHALL place the mode enum (ONES, ZEROS, LZC, TZC) and state enum (IDLE, COUNT, DONE) in a shared package bit_count_pkg.
REQ-028 SHALL instantiate one sub-module, bidir_shift_reg, parametrised by WIDTH, with load, shift-enable, direction, and zero fill; FSM and counters remain in the top module.
REQ-029 The existing seg7 decoder SHALL be usable on result[3:0] at WIDTH = 8 without an adapter.

Verification
REQ-030 WIDTH=8, ONES, data_in=0xB5, start pulse -> result=5, done after 9 COUNT cycles, busy high exactly during those cycles.
REQ-031 WIDTH=8, ZEROS, 0xB5 -> result=3; ONES, 0x00 -> result=0 after 1 COUNT cycle.
REQ-032 WIDTH=8, LZC, 0x10 -> result=3; TZC, 0x10 -> result=4; LZC, 0x00 -> result=8 after 9 COUNT cycles.
REQ-033 WIDTH=8, ONES, 0xFF, Reset asserted on the 4th COUNT cycle -> next cycle IDLE, result=0, busy=done=0.
REQ-034 WIDTH=8, start held high through DONE while data_in changes -> done stays 1 with result unchanged; start low -> IDLE; new start -> new operand counted.
REQ-035 WIDTH=16, ONES, 0xFFFF -> result=16 (RW=5, no wrap); TZC, 0x8000 -> result=15.
